// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg -- constants and types shared by the divider and its users.
//   RegBus / DoubleRegBus : operand and result widths
//   div_state_t           : divider FSM state encodings
//   DivResultReady/NotReady, DivStart/DivStop, ZeroWord, RstEnable
//   abs_val()             : operand magnitude under the signed/unsigned mode
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic RstEnable         = 1'b1;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [RegBus-1:0]       ZeroWord   = '0;
    localparam logic [DoubleRegBus-1:0] ZeroDouble = '0;

    // Two's-complement magnitude; only negative values in signed mode flip.
    function automatic logic [RegBus-1:0] abs_val(input logic               i_signed,
                                                  input logic [RegBus-1:0]  i_v);
        return (i_signed && i_v[RegBus-1]) ? (~i_v + 32'd1) : i_v;
    endfunction

endpackage

// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div -- 32-bit restoring divider, one quotient bit per clock.
//   clk          : rising-edge clock
//   rst          : asynchronous reset, active-high
//   signed_div_i : 1 = signed division, 0 = unsigned
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : start request, held high until the result is consumed
//   annul_i      : abandon the operation in progress
//   result_o     : {remainder, quotient}, registered
//   ready_o      : result valid, registered
// The dividend/divisor magnitudes and the sign-correction flags are captured
// when the operation starts, so the operand inputs are free to change while
// the iteration runs.
// ---------------------------------------------------------------------------
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_t                r_state,  w_state_nxt;
    logic [5:0]                r_cnt,    w_cnt_nxt;
    // Working register: {partial remainder, dividend/quotient shift}.
    logic [DoubleRegBus-1:0]   r_work,   w_work_nxt;
    logic [RegBus-1:0]         r_dvs,    w_dvs_nxt;
    logic                      r_neg_q,  w_neg_q_nxt;
    logic                      r_neg_r,  w_neg_r_nxt;
    logic [DoubleRegBus-1:0]   r_result, w_result_nxt;
    logic                      r_ready,  w_ready_nxt;

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value fits 33 bits and the kept value always fits 32.
    logic [RegBus:0]           w_shift;
    logic [RegBus+1:0]         w_diff;
    logic                      w_borrow;
    logic [DoubleRegBus-1:0]   w_work_step;
    logic [RegBus-1:0]         w_quo, w_rem;

    assign w_shift     = r_work[DoubleRegBus-1:RegBus-1];
    assign w_diff      = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_borrow    = w_diff[RegBus+1];
    assign w_work_step = w_borrow ? {w_shift[RegBus-1:0], r_work[RegBus-2:0], 1'b0}
                                  : {w_diff[RegBus-1:0],  r_work[RegBus-2:0], 1'b1};

    assign w_quo = r_neg_q ? (~r_work[RegBus-1:0] + 32'd1) : r_work[RegBus-1:0];
    assign w_rem = r_neg_r ? (~r_work[DoubleRegBus-1:RegBus] + 32'd1)
                           : r_work[DoubleRegBus-1:RegBus];

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_state  <= DivFree;
            r_cnt    <= '0;
            r_work   <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= ZeroDouble;
            r_ready  <= DivResultNotReady;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_work   <= w_work_nxt;
            r_dvs    <= w_dvs_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_result <= w_result_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_work_nxt   = r_work;
        w_dvs_nxt    = r_dvs;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_result_nxt = r_result;
        w_ready_nxt  = r_ready;

        unique case (r_state)
            DivFree: begin
                w_result_nxt = ZeroDouble;
                w_ready_nxt  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == ZeroWord) begin
                        w_state_nxt = DivByZero;
                    end else begin
                        w_state_nxt = DivOn;
                        w_cnt_nxt   = '0;
                        w_work_nxt  = {ZeroWord, abs_val(signed_div_i, opdata1_i)};
                        w_dvs_nxt   = abs_val(signed_div_i, opdata2_i);
                        w_neg_q_nxt = signed_div_i &&
                                      (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
                        w_neg_r_nxt = signed_div_i && opdata1_i[RegBus-1];
                    end
                end
            end
            DivByZero: begin
                w_state_nxt  = DivEnd;
                w_result_nxt = ZeroDouble;
                w_ready_nxt  = DivResultReady;
            end
            DivOn: begin
                if (annul_i) begin
                    w_state_nxt  = DivFree;
                    w_result_nxt = ZeroDouble;
                    w_ready_nxt  = DivResultNotReady;
                end else if (r_cnt != 6'd32) begin
                    w_work_nxt = w_work_step;
                    w_cnt_nxt  = r_cnt + 6'd1;
                end else begin
                    w_state_nxt  = DivEnd;
                    w_result_nxt = {w_rem, w_quo};
                    w_ready_nxt  = DivResultReady;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    w_state_nxt  = DivFree;
                    w_result_nxt = ZeroDouble;
                    w_ready_nxt  = DivResultNotReady;
                end
            end
            default: w_state_nxt = DivFree;
        endcase
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have no parameters; the 32-bit operand width and 64-bit result width SHALL come from the shared RegBus/DoubleRegBus constants.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-high. Ports are clk and rst.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous reset, active-high (RstEnable).
REQ-005 signed_div_i  input  1  1 selects signed division, 0 selects unsigned.
REQ-006 opdata1_i  input  32  dividend.
REQ-007 opdata2_i  input  32  divisor.
REQ-008 start_i  input  1  DivStart/DivStop request from EX, held high until the result is consumed.
REQ-009 annul_i  input  1  abandon the operation in progress (pipeline flush).
REQ-010 result_o  output  64  {remainder[63:32], quotient[31:0]}, registered.
REQ-011 ready_o  output  1  DivResultReady/DivResultNotReady, registered.

Function
REQ-012 The block SHALL implement an FSM with four states: DivFree, DivByZero, DivOn and DivEnd.
REQ-013 In DivFree, with start_i=1 and annul_i=0:
- divisor==0: go to DivByZero.
- otherwise: go to DivOn, clear cnt (6-bit), and load the working register with the dividend magnitude.
- Magnitude rule: two's-complement negation when signed_div_i=1 and the operand bit31=1; the same rule applies to the divisor.
REQ-014 In DivFree, with start_i=0 or annul_i=1, the block SHALL stay in DivFree with ready_o=0 and result_o=0.
REQ-015 DivByZero SHALL go to DivEnd on the next edge with the result register set to 0.
REQ-016 In DivOn, each edge SHALL perform one restoring step while cnt<32:
- Trial-subtract the divisor from the partial remainder.
- On no borrow: shift in 1 and keep the difference.
- On borrow: shift in 0 and keep the partial remainder.
- Increment cnt.
REQ-017 In DivOn, the edge on which cnt==32 SHALL perform sign correction, go to DivEnd, and set ready_o=1:
- Quotient is negated if signed_div_i=1 and the operand signs differ.
- Remainder is negated if signed_div_i=1 and the dividend is negative.
REQ-018 In DivOn, annul_i=1 SHALL force DivFree on that edge with ready_o=0 and result_o=0; a start_i re-assertion while in DivOn SHALL be ignored.
REQ-019 Latency: start is sampled on edge E0, iterations occur on E1..E32, and ready_o=1 with a valid result_o appears after E33. Divide-by-zero: ready_o=1 after E1.
REQ-020 In DivEnd, ready_o and result_o SHALL hold while start_i=1; on the first edge with start_i=0, the block SHALL go to DivFree with ready_o=0 and result_o=0.
REQ-021 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no exception.
REQ-022 Operands SHALL be sampled only in DivFree; changes on opdata*_i or signed_div_i during DivOn SHALL NOT affect the result, so the sign flags are captured at start.

Reset
REQ-023 When rst=1, asynchronously and for as long as rst is held, the block SHALL force: state=DivFree, cnt=0, working register=0, ready_o=0, result_o=0.
REQ-024 Reset asserted mid-DivOn SHALL abandon the operation; after release the block SHALL accept a new start normally.

Structure
REQ-025 The state encodings (DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11) and DivResultReady/NotReady, DivStart/DivStop and ZeroWord SHALL live in the shared defines header, not in the module.
REQ-026 The block SHALL be a single module with no sub-modules; the one-step subtract/shift datapath is inline combinational logic beside the state register.

Verification
REQ-027 Unsigned 100/7 (signed_div_i=0), start held: ready_o rises after 34 edges; result_o=64'h00000002_0000000E; ready_o drops one edge after start_i falls.
REQ-028 Signed -7/2 (0xFFFFFFF9 / 0x00000002): result_o=64'hFFFFFFFF_FFFFFFFD. Unsigned 0xFFFFFFF9/2: result_o=64'h00000001_7FFFFFFC.
REQ-029 Divide by zero (1234/0): ready_o=1 after 2 edges, result_o=0. Signed 0x80000000/0xFFFFFFFF: result_o=64'h00000000_80000000.
REQ-030 annul_i pulsed at iteration 10 of 50/5: the block returns to DivFree and ready_o never rises. A following 50/5 start completes with result_o=64'h00000000_0000000A.
REQ-031 rst asserted at iteration 20 between clock edges: ready_o and result_o are 0 immediately. After release, 9/4 unsigned yields 64'h00000001_00000002.
